// File: rtl/vx_tag_flush_pkg.sv
// Shared types and geometry helpers for the per-bank tag flush sequencer.
// Pure declarations: no latency, no backpressure.
package vx_tag_flush_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic int calc_lines(input int cache_size, input int line_size, input int num_banks);
    return cache_size / (line_size * num_banks);
  endfunction

  // A single-line bank still needs a 1-bit counter.
  function automatic int calc_lsb(input int lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

endpackage

// File: rtl/vx_flush_walker.sv
// Line-index walker: one line per non-stalled cycle while enabled, wraps after the last line.
// Latency: done is combinational on the last line; stall freezes the index.
module vx_flush_walker #(
  parameter int LINES = 8,
  parameter int LSB   = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           en,
  input  logic           stall,
  output logic [LSB-1:0] line_ctr,
  output logic           done
);

  localparam logic [LSB-1:0] LAST_IDX = LSB'(LINES - 1);

  logic last_line;

  assign last_line = (line_ctr == LAST_IDX);
  assign done      = en & ~stall & last_line;

  always_ff @(posedge clk) begin
    if (reset || start) begin
      line_ctr <= '0;
    end else if (en && !stall) begin
      line_ctr <= last_line ? '0 : line_ctr + 1'b1;
    end
  end

endmodule

// File: rtl/vx_tag_flush_ctrl.sv
// Per-bank tag-store sequencer: init/flush line walk arbitrated against core fill/lookup traffic.
// Core path is combinational in IDLE; core_ready drops during DRAIN/FLUSH/DONE. Optional PERF_TAG_FLUSH_EN adds counters.
module vx_tag_flush_ctrl
  import vx_tag_flush_pkg::*;
#(
  parameter int CACHE_SIZE      = 1024,
  parameter int CACHE_LINE_SIZE = 64,
  parameter int NUM_BANKS       = 2,
  parameter int DRAIN_CYCLES    = 2,
  parameter int LINE_ADDR_WIDTH = 26
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       flush_req_valid,
  output logic                       flush_req_ready,
  output logic                       flush_done,
  output logic                       busy,
  input  logic                       pending_empty,
  input  logic                       core_valid,
  output logic                       core_ready,
  input  logic [LINE_ADDR_WIDTH-1:0] core_addr,
  input  logic                       core_fill,
  input  logic                       core_lookup,
  input  logic                       core_reserve,
  output logic [LINE_ADDR_WIDTH-1:0] tag_addr,
  output logic                       tag_fill,
  output logic                       tag_flush,
  output logic                       tag_lookup,
  output logic                       tag_reserve
`ifdef PERF_TAG_FLUSH_EN
  ,
  output logic [43:0]                perf_flush_cycles,
  output logic [31:0]                perf_flushes
`endif
);

  localparam int LINES_PER_BANK = calc_lines(CACHE_SIZE, CACHE_LINE_SIZE, NUM_BANKS);
  localparam int LSB            = calc_lsb(LINES_PER_BANK);
  localparam int DW             = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DRAIN_MAX = DW'(DRAIN_CYCLES);

  state_e         state, state_n;
  logic [LSB-1:0] line_ctr;
  logic [DW-1:0]  drain_ctr;
  logic           walk_en, walk_start, walk_done, drain_clr;

  assign walk_en = (state == ST_INIT) || (state == ST_FLUSH);

  vx_flush_walker #(
    .LINES (LINES_PER_BANK),
    .LSB   (LSB)
  ) u_walker (
    .clk      (clk),
    .reset    (reset),
    .start    (walk_start),
    .en       (walk_en),
    .stall    (stall),
    .line_ctr (line_ctr),
    .done     (walk_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_INIT;
      drain_ctr <= '0;
    end else begin
      state <= state_n;
      if (drain_clr) begin
        drain_ctr <= '0;
      end else if (state == ST_DRAIN && drain_ctr != DRAIN_MAX) begin
        drain_ctr <= drain_ctr + 1'b1;
      end
    end
  end

  // Reset overrides every state so nothing reaches the tag store mid-abort.
  always_comb begin
    state_n         = state;
    walk_start      = 1'b0;
    drain_clr       = 1'b0;
    tag_addr        = '0;
    tag_fill        = 1'b0;
    tag_flush       = 1'b0;
    tag_lookup      = 1'b0;
    tag_reserve     = 1'b0;
    core_ready      = 1'b0;
    flush_req_ready = 1'b0;
    flush_done      = 1'b0;
    busy            = 1'b1;
    if (!reset) begin
      case (state)
        ST_INIT, ST_FLUSH: begin
          tag_flush = ~stall;
          tag_addr  = LINE_ADDR_WIDTH'(line_ctr);
          if (walk_done) state_n = (state == ST_INIT) ? ST_IDLE : ST_DONE;
        end
        ST_IDLE: begin
          busy            = 1'b0;
          core_ready      = 1'b1;
          flush_req_ready = 1'b1;
          tag_addr        = core_addr;
          tag_fill        = core_valid & core_fill;
          tag_lookup      = core_valid & core_lookup;
          tag_reserve     = core_valid & core_fill & core_reserve;
          if (flush_req_valid) begin
            state_n   = ST_DRAIN;
            drain_clr = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_ctr == DRAIN_MAX && pending_empty) begin
            state_n    = ST_FLUSH;
            walk_start = 1'b1;
          end
        end
        ST_DONE: begin
          flush_done = 1'b1;
          state_n    = ST_IDLE;
        end
        default: state_n = ST_INIT;
      endcase
    end
  end

`ifdef PERF_TAG_FLUSH_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_flush_cycles <= '0;
      perf_flushes      <= '0;
    end else begin
      if (state inside {ST_DRAIN, ST_FLUSH, ST_DONE}) perf_flush_cycles <= perf_flush_cycles + 44'd1;
      if (state == ST_DONE) perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_tag_flush_ctrl.sv
// Directed bench for vx_tag_flush_ctrl (8 lines per bank, DRAIN_CYCLES=2).
module tb_vx_tag_flush_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush_req_valid = 1'b0;
  logic        pending_empty = 1'b1;
  logic        core_valid = 1'b0;
  logic        core_fill = 1'b0;
  logic        core_lookup = 1'b0;
  logic        core_reserve = 1'b0;
  logic [25:0] core_addr = '0;

  logic        flush_req_ready, flush_done, busy, core_ready;
  logic [25:0] tag_addr;
  logic        tag_fill, tag_flush, tag_lookup, tag_reserve;
`ifdef PERF_TAG_FLUSH_EN
  logic [43:0] perf_flush_cycles;
  logic [31:0] perf_flushes;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vx_tag_flush_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .flush_req_valid (flush_req_valid),
    .flush_req_ready (flush_req_ready),
    .flush_done      (flush_done),
    .busy            (busy),
    .pending_empty   (pending_empty),
    .core_valid      (core_valid),
    .core_ready      (core_ready),
    .core_addr       (core_addr),
    .core_fill       (core_fill),
    .core_lookup     (core_lookup),
    .core_reserve    (core_reserve),
    .tag_addr        (tag_addr),
    .tag_fill        (tag_fill),
    .tag_flush       (tag_flush),
    .tag_lookup      (tag_lookup),
    .tag_reserve     (tag_reserve)
`ifdef PERF_TAG_FLUSH_EN
    ,
    .perf_flush_cycles (perf_flush_cycles),
    .perf_flushes      (perf_flushes)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change just after a rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_walk(input string tag, input int idx, input logic fl);
    smp();
    chk({tag, "_flush"}, 64'(tag_flush), 64'(fl));
    chk({tag, "_addr"}, 64'(tag_addr), 64'(idx));
    chk({tag, "_core_ready"}, 64'(core_ready), 64'd0);
    chk({tag, "_done"}, 64'(flush_done), 64'd0);
    chk({tag, "_fill"}, 64'(tag_fill), 64'd0);
  endtask

  task automatic chk_idle(input string tag);
    smp();
    chk({tag, "_core_ready"}, 64'(core_ready), 64'd1);
    chk({tag, "_req_ready"}, 64'(flush_req_ready), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(flush_done), 64'd0);
    chk({tag, "_flush"}, 64'(tag_flush), 64'd0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      smp();
      chk("rst_flush", 64'(tag_flush), 64'd0);
      chk("rst_fill", 64'(tag_fill), 64'd0);
      chk("rst_core_ready", 64'(core_ready), 64'd0);
      chk("rst_req_ready", 64'(flush_req_ready), 64'd0);
      chk("rst_done", 64'(flush_done), 64'd0);
      chk("rst_busy", 64'(busy), 64'd1);
      cyc();
    end
    reset = 1'b0;
  endtask

  initial begin
    // Power-on INIT walk, no stall.
    do_reset(3);
    for (int i = 0; i < 8; i++) begin
      chk_walk("init", i, 1'b1);
      cyc();
    end
    chk_idle("init_end");

    // INIT walk with stall on line 3: nine cycles total.
    cyc();
    do_reset(3);
    for (int i = 0; i < 3; i++) begin
      chk_walk("stw", i, 1'b1);
      cyc();
    end
    stall = 1'b1;
    chk_walk("stw_stalled", 3, 1'b0);
    cyc();
    stall = 1'b0;
    for (int i = 3; i < 8; i++) begin
      chk_walk("stw", i, 1'b1);
      cyc();
    end
    chk_idle("stw_end");
    cyc();

    // IDLE pass-through patterns.
    core_valid = 1'b1; core_lookup = 1'b1; core_addr = 26'h2A;
    smp();
    chk("pt_lookup", 64'(tag_lookup), 64'd1);
    chk("pt_lookup_fill", 64'(tag_fill), 64'd0);
    chk("pt_lookup_addr", 64'(tag_addr), 64'h2A);
    chk("pt_lookup_rsv", 64'(tag_reserve), 64'd0);
    cyc();
    core_valid = 1'b0; core_lookup = 1'b0; core_fill = 1'b1; core_reserve = 1'b1;
    smp();
    chk("pt_novalid_fill", 64'(tag_fill), 64'd0);
    chk("pt_novalid_rsv", 64'(tag_reserve), 64'd0);
    cyc();

    // Simultaneous fill and flush request.
    core_valid = 1'b1; core_addr = 26'h15; flush_req_valid = 1'b1; pending_empty = 1'b0;
    smp();
    chk("sim_fill", 64'(tag_fill), 64'd1);
    chk("sim_addr", 64'(tag_addr), 64'h15);
    chk("sim_rsv", 64'(tag_reserve), 64'd1);
    chk("sim_req_ready", 64'(flush_req_ready), 64'd1);
    chk("sim_core_ready", 64'(core_ready), 64'd1);
    chk("sim_flush", 64'(tag_flush), 64'd0);
    cyc();
    flush_req_valid = 1'b0;

    // DRAIN held by pending_empty low for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("drn_core_ready", 64'(core_ready), 64'd0);
      chk("drn_fill", 64'(tag_fill), 64'd0);
      chk("drn_flush", 64'(tag_flush), 64'd0);
      chk("drn_req_ready", 64'(flush_req_ready), 64'd0);
      chk("drn_busy", 64'(busy), 64'd1);
      cyc();
    end
    pending_empty = 1'b1; core_valid = 1'b0; core_fill = 1'b0; core_reserve = 1'b0;
    smp();
    chk("drn_last_flush", 64'(tag_flush), 64'd0);
    cyc();
    for (int i = 0; i < 8; i++) begin
      chk_walk("flw", i, 1'b1);
      cyc();
    end
    flush_req_valid = 1'b1;
    smp();
    chk("done_pulse", 64'(flush_done), 64'd1);
    chk("done_req_ready", 64'(flush_req_ready), 64'd0);
    chk("done_busy", 64'(busy), 64'd1);
    chk("done_flush", 64'(tag_flush), 64'd0);
    cyc();
    chk_idle("post_done");
`ifdef PERF_TAG_FLUSH_EN
    chk("perf_flushes", 64'(perf_flushes), 64'd1);
    chk("perf_cycles", 64'(perf_flush_cycles), 64'd15);
`endif
    cyc();
    flush_req_valid = 1'b0;

    // Held request accepted; minimum 3-cycle DRAIN, then reset at line 4.
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("drn2_flush", 64'(tag_flush), 64'd0);
      chk("drn2_busy", 64'(busy), 64'd1);
      chk("drn2_core_ready", 64'(core_ready), 64'd0);
      cyc();
    end
    for (int i = 0; i < 5; i++) begin
      chk_walk("abw", i, 1'b1);
      cyc();
    end
    do_reset(2);
    for (int i = 0; i < 8; i++) begin
      chk_walk("reinit", i, 1'b1);
      cyc();
    end
    chk_idle("reinit_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
